// File: rtl/hdmi_tx_pkg.sv
// Shared timing constants, TMDS control tokens and encoder helpers for the
// 720x480p60 DVI source.
package hdmi_tx_pkg;

   localparam int H_ACTIVE = 720;
   localparam int H_FRONT  = 16;
   localparam int H_SYNC   = 62;
   localparam int H_BACK   = 60;
   localparam int V_ACTIVE = 480;
   localparam int V_FRONT  = 9;
   localparam int V_SYNC   = 6;
   localparam int V_BACK   = 30;
   localparam logic SYNC_POL = 1'b0;

   localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
   localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
   localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
   localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
   localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;
   localparam logic [9:0] CLOCK_SYMBOL  = 10'b0000011111;

   typedef struct packed {
      logic de;
      logic hsync;
      logic vsync;
   } pixelCtrl_t;

   function automatic logic [3:0] countOnes(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
      return n;
   endfunction

   // Stage one of 8b/10b: pick XOR or XNOR chaining to minimise transitions.
   function automatic logic [8:0] transitionMin(input logic [7:0] d);
      logic [8:0] q;
      logic [3:0] n1;
      logic useXnor;
      n1 = countOnes(d);
      useXnor = (n1 > 4'd4) || (n1 == 4'd4 && !d[0]);
      q[0] = d[0];
      for (int i = 1; i < 8; i++) q[i] = useXnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      q[8] = ~useXnor;
      return q;
   endfunction

   function automatic logic [9:0] ctrlToken(input logic [1:0] c);
      case (c)
         2'b00:   return CTRL_TOKEN_00;
         2'b01:   return CTRL_TOKEN_01;
         2'b10:   return CTRL_TOKEN_10;
         default: return CTRL_TOKEN_11;
      endcase
   endfunction

endpackage

// File: rtl/tmds_channel_encoder.sv
// One TMDS lane: 8b/10b data encode with running disparity, or control token
// during blanking. Output is registered.
module tmds_channel_encoder
   import hdmi_tx_pkg::*;
#(
   parameter logic [9:0] RESET_SYMBOL = CTRL_TOKEN_00
) (
   input  logic       pixelClock,
   input  logic       reset,
   input  logic [7:0] data,
   input  logic       de,
   input  logic       c0,
   input  logic       c1,
   output logic [9:0] symbol
);

   logic [8:0]        qm;
   logic [3:0]        n1Qm;
   logic signed [4:0] disparity, diff, disparityNext;
   logic [9:0]        symbolNext;

   always_comb begin
      qm            = transitionMin(data);
      n1Qm          = countOnes(qm[7:0]);
      // N1-N0 of q_m, computed mod 32; the true result always fits in 5 bits.
      diff          = $signed({n1Qm, 1'b0}) - 5'sd8;
      symbolNext    = ctrlToken({c1, c0});
      disparityNext = 5'sd0;
      if (de) begin
         if (disparity == 5'sd0 || n1Qm == 4'd4) begin
            symbolNext    = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            disparityNext = qm[8] ? disparity + diff : disparity - diff;
         end else if ((!disparity[4] && n1Qm > 4'd4) || (disparity[4] && n1Qm < 4'd4)) begin
            symbolNext    = {1'b1, qm[8], ~qm[7:0]};
            disparityNext = disparity - diff + (qm[8] ? 5'sd2 : 5'sd0);
         end else begin
            symbolNext    = {1'b0, qm[8], qm[7:0]};
            disparityNext = disparity + diff - (qm[8] ? 5'sd0 : 5'sd2);
         end
      end
   end

   always_ff @(posedge pixelClock or posedge reset) begin
      if (reset) begin
         symbol    <= RESET_SYMBOL;
         disparity <= 5'sd0;
      end else begin
         symbol    <= symbolNext;
         disparity <= disparityNext;
      end
   end

endmodule

// File: rtl/hdmi_tx_core.sv
// 720x480p60 DVI source core: raster counters, sync/DE decode and a two-stage
// pipeline into three TMDS lane encoders (lane 0 blue, 1 green, 2 red).
module hdmi_tx_core
   import hdmi_tx_pkg::*;
(
   input  logic               pixelClock,
   input  logic               reset,
   input  logic [7:0]         redByte,
   input  logic [7:0]         greenByte,
   input  logic [7:0]         blueByte,
   output logic               inActiveDisplay,
   output logic signed [11:0] hPosCounter,
   output logic signed [10:0] vPosCounter,
   output logic [9:0]         tmdsSymbol0,
   output logic [9:0]         tmdsSymbol1,
   output logic [9:0]         tmdsSymbol2,
   output logic [9:0]         tmdsClockSymbol
);

   localparam int NUM_LANES = 3;

   // Blanking occupies the negative counter range so active video starts at 0.
   localparam logic signed [11:0] H_FIRST  = 12'(-H_BLANK);
   localparam logic signed [11:0] H_LAST   = 12'(H_ACTIVE - 1);
   localparam logic signed [11:0] HS_FIRST = 12'(H_FRONT - H_BLANK);
   localparam logic signed [11:0] HS_LAST  = 12'(H_FRONT + H_SYNC - 1 - H_BLANK);
   localparam logic signed [10:0] V_FIRST  = 11'(-V_BLANK);
   localparam logic signed [10:0] V_LAST   = 11'(V_ACTIVE - 1);
   localparam logic signed [10:0] VS_FIRST = 11'(V_FRONT - V_BLANK);
   localparam logic signed [10:0] VS_LAST  = 11'(V_FRONT + V_SYNC - 1 - V_BLANK);

   logic                             hsyncNow, vsyncNow;
   logic [NUM_LANES-1:0][7:0]        pixelQ;
   pixelCtrl_t                       ctrlQ;
   logic [NUM_LANES-1:0][9:0]        laneSymbol;

   always_ff @(posedge pixelClock or posedge reset) begin
      if (reset) begin
         hPosCounter <= H_FIRST;
         vPosCounter <= V_FIRST;
      end else if (hPosCounter == H_LAST) begin
         hPosCounter <= H_FIRST;
         vPosCounter <= (vPosCounter == V_LAST) ? V_FIRST : vPosCounter + 11'sd1;
      end else begin
         hPosCounter <= hPosCounter + 12'sd1;
      end
   end

   assign inActiveDisplay = !hPosCounter[11] && !vPosCounter[10];
   assign hsyncNow = (hPosCounter >= HS_FIRST && hPosCounter <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
   assign vsyncNow = (vPosCounter >= VS_FIRST && vPosCounter <= VS_LAST) ? SYNC_POL : ~SYNC_POL;

   always_ff @(posedge pixelClock or posedge reset) begin
      if (reset) begin
         pixelQ <= '0;
         ctrlQ  <= '{de: 1'b0, hsync: ~SYNC_POL, vsync: ~SYNC_POL};
      end else begin
         pixelQ <= {redByte, greenByte, blueByte};
         ctrlQ  <= '{de: inActiveDisplay, hsync: hsyncNow, vsync: vsyncNow};
      end
   end

   // Only the blue lane carries syncs; the others always send the 00 token.
   for (genvar lane = 0; lane < NUM_LANES; lane++) begin : gLane
      tmds_channel_encoder #(
         .RESET_SYMBOL(lane == 0 ? ctrlToken({~SYNC_POL, ~SYNC_POL}) : ctrlToken(2'b00))
      ) uEnc (
         .pixelClock (pixelClock),
         .reset      (reset),
         .data       (pixelQ[lane]),
         .de         (ctrlQ.de),
         .c0         (lane == 0 ? ctrlQ.hsync : 1'b0),
         .c1         (lane == 0 ? ctrlQ.vsync : 1'b0),
         .symbol     (laneSymbol[lane])
      );
   end

   assign tmdsSymbol0     = laneSymbol[0];
   assign tmdsSymbol1     = laneSymbol[1];
   assign tmdsSymbol2     = laneSymbol[2];
   assign tmdsClockSymbol = CLOCK_SYMBOL;

endmodule

// File: tb/tb_hdmi_tx_core.sv
// Random-pixel bench for hdmi_tx_core against a frame-position / TMDS reference model.
module tb_hdmi_tx_core;

   logic               pixelClock = 1'b0;
   logic               reset;
   logic [7:0]         redByte, greenByte, blueByte;
   logic               inActiveDisplay;
   logic signed [11:0] hPosCounter;
   logic signed [10:0] vPosCounter;
   logic [9:0]         tmdsSymbol0, tmdsSymbol1, tmdsSymbol2, tmdsClockSymbol;

   int          checks   = 0;
   int          failures = 0;
   int          cyc;
   int          disp [3];
   logic [29:0] expQ [$];

   localparam logic [29:0] RESET_ENTRY = {10'b1101010100, 10'b1101010100, 10'b1010101011};

   hdmi_tx_core dut (
      .pixelClock      (pixelClock),
      .reset           (reset),
      .redByte         (redByte),
      .greenByte       (greenByte),
      .blueByte        (blueByte),
      .inActiveDisplay (inActiveDisplay),
      .hPosCounter     (hPosCounter),
      .vPosCounter     (vPosCounter),
      .tmdsSymbol0     (tmdsSymbol0),
      .tmdsSymbol1     (tmdsSymbol1),
      .tmdsSymbol2     (tmdsSymbol2),
      .tmdsClockSymbol (tmdsClockSymbol)
   );

   always #5 pixelClock = ~pixelClock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [9:0] ctrlTok(input logic c1, input logic c0);
      case ({c1, c0})
         2'b00:   return 10'b1101010100;
         2'b01:   return 10'b0010101011;
         2'b10:   return 10'b0101010100;
         default: return 10'b1010101011;
      endcase
   endfunction

   // q_m bit i is the parity of d[i:0]; the XNOR chain adds one inversion per step.
   task automatic encRef(input int ch, input logic [7:0] d, output logic [9:0] q);
      int         n1, n0, ones;
      logic       xm;
      logic [7:0] mask;
      logic [8:0] qm;
      ones = $countones(d);
      xm   = (ones > 4) || (ones == 4 && !d[0]);
      for (int i = 0; i < 8; i++) begin
         mask  = 8'((1 << (i + 1)) - 1);
         qm[i] = (^(d & mask)) ^ (xm && (i % 2 == 1));
      end
      qm[8] = !xm;
      n1 = $countones(qm[7:0]);
      n0 = 8 - n1;
      if (disp[ch] == 0 || n1 == n0) begin
         q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         disp[ch] += qm[8] ? (n1 - n0) : (n0 - n1);
      end else if ((disp[ch] > 0 && n1 > n0) || (disp[ch] < 0 && n0 > n1)) begin
         q = {1'b1, qm[8], ~qm[7:0]};
         disp[ch] += (qm[8] ? 2 : 0) + (n0 - n1);
      end else begin
         q = {1'b0, qm[8], qm[7:0]};
         disp[ch] += (n1 - n0) - (qm[8] ? 0 : 2);
      end
   endtask

   task automatic modelRestart();
      cyc  = 0;
      disp = '{0, 0, 0};
      expQ = {};
      expQ.push_back(RESET_ENTRY);
      expQ.push_back(RESET_ENTRY);
   endtask

   task automatic chkReset(input string tag);
      chk({tag, "_h"},   32'(int'(hPosCounter)), 32'(-138));
      chk({tag, "_v"},   32'(int'(vPosCounter)), 32'(-45));
      chk({tag, "_de"},  32'(inActiveDisplay), 32'd0);
      chk({tag, "_s0"},  32'(tmdsSymbol0), 32'(10'b1010101011));
      chk({tag, "_s1"},  32'(tmdsSymbol1), 32'(10'b1101010100));
      chk({tag, "_s2"},  32'(tmdsSymbol2), 32'(10'b1101010100));
      chk({tag, "_clk"}, 32'(tmdsClockSymbol), 32'(10'b0000011111));
   endtask

   task automatic runCycles(input int n);
      int          p, h, v;
      logic        de, hs, vs;
      logic [29:0] e;
      logic [9:0]  q0, q1, q2;
      for (int k = 0; k < n; k++) begin
         p  = cyc % (858 * 525);
         h  = p % 858 - 138;
         v  = p / 858 - 45;
         de = (h >= 0 && v >= 0);
         hs = !(h >= -122 && h <= -61);
         vs = !(v >= -36 && v <= -31);
         chk("hPos", 32'(int'(hPosCounter)), 32'(h));
         chk("vPos", 32'(int'(vPosCounter)), 32'(v));
         chk("de",   32'(inActiveDisplay), 32'(de));
         e = expQ.pop_front();
         chk("sym0", 32'(tmdsSymbol0), 32'(e[9:0]));
         chk("sym1", 32'(tmdsSymbol1), 32'(e[19:10]));
         chk("sym2", 32'(tmdsSymbol2), 32'(e[29:20]));
         if (v == 0 && h == 2) begin
            chk("zeroFirst", 32'(tmdsSymbol0), 32'(10'b0100000000));
            chk("ffFirst",   32'(tmdsSymbol2), 32'(10'b1000000000));
         end
         if (v == 0 && h == 3) chk("zeroSecond", 32'(tmdsSymbol0), 32'(10'b1111111111));

         redByte   = 8'($urandom);
         greenByte = 8'($urandom);
         blueByte  = 8'($urandom);
         if (v == 0 && h == 0) begin
            redByte = 8'hFF; greenByte = 8'h00; blueByte = 8'h00;
         end
         if (v == 0 && h == 1) blueByte = 8'h00;
         if (de) begin
            encRef(0, blueByte, q0);
            encRef(1, greenByte, q1);
            encRef(2, redByte, q2);
         end else begin
            q0   = ctrlTok(vs, hs);
            q1   = ctrlTok(1'b0, 1'b0);
            q2   = ctrlTok(1'b0, 1'b0);
            disp = '{0, 0, 0};
         end
         expQ.push_back({q2, q1, q0});
         @(posedge pixelClock);
         #1;
         cyc++;
      end
   endtask

   initial begin
      reset = 1'b1;
      redByte = 8'h00; greenByte = 8'h00; blueByte = 8'h00;
      cyc = 0;
      repeat (3) @(posedge pixelClock);
      #1;
      chkReset("rst");
      @(negedge pixelClock);
      reset = 1'b0;
      modelRestart();
      // Vertical blanking, first active pixels and a few active lines.
      runCycles(48 * 858);

      // Asynchronous reset mid-line, away from any clock edge.
      #2 reset = 1'b1;
      #1 chkReset("midRst");
      @(negedge pixelClock);
      reset = 1'b0;
      modelRestart();
      runCycles(400);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
